// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin arbiter and sequencer sharing one 32-bit ALU
// between two valid/ready requesters. Operands are registered and held on
// the ALU for SETTLE_CYCLES before result and flags are captured and returned
// on a single tagged response channel.
//
// Optional build macro: ALU_ARB_STATS_EN adds saturating per-requester grant
// counters and a response-stall counter.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | choosing a requester; ready asserted towards the grant
// EXEC  | operands held on the ALU while the settle counter runs down
// RESP  | result captured; waiting for the consumer to take it

module alu (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [2:0]  cmd,
    output logic [31:0] result,
    output logic        carryout,
    output logic        zero,
    output logic        overflow
);
    logic [32:0] sum;

    // Combinational ALU; carry and overflow exist only for ADD and SUB
    always_comb begin
        sum      = 33'd0;
        result   = 32'd0;
        carryout = 1'b0;
        overflow = 1'b0;
        case (cmd)
            3'd0: begin
                sum      = {1'b0, a} + {1'b0, b};
                result   = sum[31:0];
                carryout = sum[32];
                overflow = (a[31] == b[31]) && (sum[31] != a[31]);
            end
            3'd1: begin
                sum      = {1'b0, a} + {1'b0, ~b} + 33'd1;
                result   = sum[31:0];
                carryout = sum[32];
                overflow = (a[31] != b[31]) && (sum[31] != a[31]);
            end
            3'd2: result = a ^ b;
            3'd3: result = {31'd0, $signed(a) < $signed(b)};
            3'd4: result = a & b;
            3'd5: result = ~(a & b);
            3'd6: result = ~(a | b);
            default: result = a | b;
        endcase
        zero = (result == 32'd0);
    end
endmodule

module alu_arbiter #(
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        r0_valid,
    output logic        r0_ready,
    input  logic [31:0] r0_a,
    input  logic [31:0] r0_b,
    input  logic [2:0]  r0_cmd,
    input  logic        r1_valid,
    output logic        r1_ready,
    input  logic [31:0] r1_a,
    input  logic [31:0] r1_b,
    input  logic [2:0]  r1_cmd,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [31:0] rsp_result,
    output logic        rsp_carryout,
    output logic        rsp_zero,
    output logic        rsp_overflow
`ifdef ALU_ARB_STATS_EN
    ,
    output logic [15:0] stat_grant0,
    output logic [15:0] stat_grant1,
    output logic [15:0] stat_stall
`endif
);
    typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_t;

    localparam logic [3:0] CNT_LOAD = 4'(SETTLE_CYCLES - 1);

    state_t      state_q, state_d;
    logic        ptr_q;
    logic        grant;
    logic        accept;
    logic [31:0] a_q, b_q;
    logic [2:0]  cmd_q;
    logic        id_q;
    logic [3:0]  cnt_q;
    logic [31:0] alu_result;
    logic        alu_carryout, alu_zero, alu_overflow;

    // ALU sees only the registered operands, never the request ports
    alu u_alu (
        .a        (a_q),
        .b        (b_q),
        .cmd      (cmd_q),
        .result   (alu_result),
        .carryout (alu_carryout),
        .zero     (alu_zero),
        .overflow (alu_overflow)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept)           state_d = EXEC;
            EXEC:    if (cnt_q == 4'd0)    state_d = RESP;
            RESP:    if (rsp_ready)        state_d = IDLE;
            default:                       state_d = IDLE;
        endcase
    end

    // Grant selection and ready outputs; pointer only matters when both ask
    always_comb begin
        grant    = (r0_valid && r1_valid) ? ptr_q : r1_valid;
        r0_ready = (state_q == IDLE) && r0_valid && !grant;
        r1_ready = (state_q == IDLE) && r1_valid && grant;
        accept   = r0_ready || r1_ready;
    end

    // Operand capture, settle down-counter, response registers and pointer
    always_ff @(posedge clk) begin
        if (reset) begin
            a_q          <= 32'd0;
            b_q          <= 32'd0;
            cmd_q        <= 3'd0;
            id_q         <= 1'b0;
            cnt_q        <= 4'd0;
            ptr_q        <= 1'b0;
            rsp_valid    <= 1'b0;
            rsp_id       <= 1'b0;
            rsp_result   <= 32'd0;
            rsp_carryout <= 1'b0;
            rsp_zero     <= 1'b0;
            rsp_overflow <= 1'b0;
        end else begin
            if (accept) begin
                a_q   <= grant ? r1_a : r0_a;
                b_q   <= grant ? r1_b : r0_b;
                cmd_q <= grant ? r1_cmd : r0_cmd;
                id_q  <= grant;
                cnt_q <= CNT_LOAD;
            end
            if (state_q == EXEC) begin
                if (cnt_q != 4'd0) begin
                    cnt_q <= cnt_q - 4'd1;
                end else begin
                    rsp_valid    <= 1'b1;
                    rsp_id       <= id_q;
                    rsp_result   <= alu_result;
                    rsp_carryout <= alu_carryout;
                    rsp_zero     <= alu_zero;
                    rsp_overflow <= alu_overflow;
                end
            end
            if (state_q == RESP && rsp_ready) begin
                rsp_valid <= 1'b0;
                ptr_q     <= ~id_q;
            end
        end
    end

`ifdef ALU_ARB_STATS_EN
    // Saturating grant and response-stall counters
    always_ff @(posedge clk) begin
        if (reset) begin
            stat_grant0 <= 16'd0;
            stat_grant1 <= 16'd0;
            stat_stall  <= 16'd0;
        end else begin
            if (r0_ready && stat_grant0 != 16'hFFFF) stat_grant0 <= stat_grant0 + 16'd1;
            if (r1_ready && stat_grant1 != 16'hFFFF) stat_grant1 <= stat_grant1 + 16'd1;
            if (state_q == RESP && !rsp_ready && stat_stall != 16'hFFFF)
                stat_stall <= stat_stall + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter with SETTLE_CYCLES = 4.
module tb_alu_arbiter;
    localparam int SETTLE = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        r0_valid, r0_ready;
    logic [31:0] r0_a, r0_b;
    logic [2:0]  r0_cmd;
    logic        r1_valid, r1_ready;
    logic [31:0] r1_a, r1_b;
    logic [2:0]  r1_cmd;
    logic        rsp_valid, rsp_ready, rsp_id;
    logic [31:0] rsp_result;
    logic        rsp_carryout, rsp_zero, rsp_overflow;
`ifdef ALU_ARB_STATS_EN
    logic [15:0] stat_grant0, stat_grant1, stat_stall;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    bit ptr      = 1'b0;
    int exp_g0   = 0;
    int exp_g1   = 0;
    int exp_st   = 0;

    alu_arbiter #(.SETTLE_CYCLES(SETTLE)) dut (
        .clk          (clk),
        .reset        (reset),
        .r0_valid     (r0_valid),
        .r0_ready     (r0_ready),
        .r0_a         (r0_a),
        .r0_b         (r0_b),
        .r0_cmd       (r0_cmd),
        .r1_valid     (r1_valid),
        .r1_ready     (r1_ready),
        .r1_a         (r1_a),
        .r1_b         (r1_b),
        .r1_cmd       (r1_cmd),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_id       (rsp_id),
        .rsp_result   (rsp_result),
        .rsp_carryout (rsp_carryout),
        .rsp_zero     (rsp_zero),
        .rsp_overflow (rsp_overflow)
`ifdef ALU_ARB_STATS_EN
        ,
        .stat_grant0  (stat_grant0),
        .stat_grant1  (stat_grant1),
        .stat_stall   (stat_stall)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference ALU computed with wide signed/unsigned arithmetic
    task automatic ref_alu(input logic [31:0] a, input logic [31:0] b, input logic [2:0] cmd,
                           output logic [31:0] res, output bit cy, output bit z, output bit ov);
        longint sa, sb, ss;
        longint unsigned ua, ub;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        cy = 1'b0;
        ov = 1'b0;
        case (cmd)
            3'd0: begin
                res = a + b;
                cy  = (ua + ub) > 64'hFFFF_FFFF;
                ss  = sa + sb;
                ov  = (ss > 64'sd2147483647) || (ss < -64'sd2147483648);
            end
            3'd1: begin
                res = a - b;
                cy  = (ua >= ub);
                ss  = sa - sb;
                ov  = (ss > 64'sd2147483647) || (ss < -64'sd2147483648);
            end
            3'd2: res = a ^ b;
            3'd3: res = (sa < sb) ? 32'd1 : 32'd0;
            3'd4: res = a & b;
            3'd5: res = ~(a & b);
            3'd6: res = ~(a | b);
            default: res = a | b;
        endcase
        z = (res == 32'd0);
    endtask

    // Present a request (called at a negedge), follow it through to the
    // response handshake, holding rsp_ready low for 'stall' RESP cycles.
    task automatic issue(input bit v0, input bit v1,
                         input logic [31:0] a0, input logic [31:0] b0, input logic [2:0] c0,
                         input logic [31:0] a1, input logic [31:0] b1, input logic [2:0] c1,
                         input int stall);
        int waits, lat;
        bit g;
        logic [31:0] ea, eb, er, held;
        logic [2:0] ec;
        bit ecy, ez, eo;
        r0_valid = v0; r0_a = a0; r0_b = b0; r0_cmd = c0;
        r1_valid = v1; r1_a = a1; r1_b = b1; r1_cmd = c1;
        rsp_ready = 1'b0;
        #1;
        waits = 0;
        while (!(r0_ready || r1_ready) && waits < 20) begin
            @(negedge clk); #1; waits++;
        end
        chk("one_hot_ready", r0_ready & r1_ready, 0);
        chk("idle_gap", waits, 0);
        g = r1_ready;
        chk("grant", g, (v0 && v1) ? ptr : v1);
        ea = g ? a1 : a0;
        eb = g ? b1 : b0;
        ec = g ? c1 : c0;
        @(posedge clk);
        if (g) exp_g1++; else exp_g0++;
        @(negedge clk);
        lat = 0;
        while (!rsp_valid && lat < 50) begin
            chk("exec_no_ready", r0_ready | r1_ready, 0);
            @(negedge clk);
            lat++;
        end
        chk("latency", lat, SETTLE);
        ref_alu(ea, eb, ec, er, ecy, ez, eo);
        chk("rsp_id", rsp_id, g);
        chk("result", rsp_result, er);
        chk("carryout", rsp_carryout, ecy);
        chk("zero", rsp_zero, ez);
        chk("overflow", rsp_overflow, eo);
        held = rsp_result;
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            chk("stall_valid", rsp_valid, 1);
            chk("stall_result", rsp_result, held);
            chk("stall_flags", {rsp_carryout, rsp_zero, rsp_overflow}, {ecy, ez, eo});
            chk("stall_no_ready", r0_ready | r1_ready, 0);
        end
        exp_st += stall;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("rsp_cleared", rsp_valid, 0);
        chk("result_kept", rsp_result, held);
        ptr = ~g;
    endtask

    initial begin
        logic [31:0] ra, rb;
        logic [2:0]  rc;
        bit rv0, rv1;
        reset = 1'b1; rsp_ready = 1'b0;
        r0_valid = 0; r0_a = 0; r0_b = 0; r0_cmd = 0;
        r1_valid = 0; r1_a = 0; r1_b = 0; r1_cmd = 0;
        repeat (2) @(negedge clk);
        chk("reset_rsp", {rsp_valid, rsp_id, rsp_result, rsp_carryout, rsp_zero, rsp_overflow}, 0);
        chk("reset_ready", {r0_ready, r1_ready}, 0);
        reset = 1'b0;
        @(negedge clk);

        // Directed ALU cases
        issue(1, 0, 32'h7FFF_FFFF, 32'h1, 3'd0, 0, 0, 0, 0);
        issue(0, 1, 0, 0, 0, 32'd5, 32'd5, 3'd1, 0);
        issue(0, 1, 0, 0, 0, 32'hFFFF_FFFF, 32'd1, 3'd3, 1);
        issue(1, 0, 32'hF0F0_1234, 32'h0FF0_FFFF, 3'd5, 0, 0, 0, 0);
        issue(1, 0, 32'h8000_0000, 32'h1, 3'd1, 0, 0, 0, 0);

        // Both valid throughout: alternating grants, one op with backpressure
        for (int i = 0; i < 8; i++)
            issue(1, 1, $urandom, $urandom, 3'($urandom_range(0, 7)),
                  $urandom, $urandom, 3'($urandom_range(0, 7)), (i == 3) ? 5 : 0);

        // Random mix of requesters, commands and stalls
        for (int i = 0; i < 12; i++) begin
            rv0 = 1'($urandom_range(0, 1));
            rv1 = rv0 ? 1'($urandom_range(0, 1)) : 1'b1;
            ra = $urandom; rb = ($urandom_range(0, 3) == 0) ? ra : $urandom;
            rc = 3'($urandom_range(0, 7));
            issue(rv0, rv1, ra, rb, rc, $urandom, $urandom, 3'($urandom_range(0, 7)),
                  $urandom_range(0, 2));
        end

        // Reset during EXEC: make pointer favour r1 first, then abort an op
        r1_valid = 0;
        issue(1, 0, 32'd9, 32'd3, 3'd0, 0, 0, 0, 0);
        r0_valid = 0;
        r1_valid = 1; r1_a = 32'd1; r1_b = 32'd2; r1_cmd = 3'd0;
        #1;
        chk("pre_abort_ready", r1_ready, 1);
        @(posedge clk);
        @(negedge clk);
        r1_valid = 0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        ptr = 1'b0; exp_g0 = 0; exp_g1 = 0; exp_st = 0;
        chk("abort_outputs", {rsp_valid, rsp_id, rsp_result, rsp_carryout, rsp_zero, rsp_overflow}, 0);
        rsp_ready = 1'b1;
        for (int i = 0; i < SETTLE + 4; i++) begin
            @(negedge clk);
            chk("abort_no_rsp", rsp_valid, 0);
        end
        rsp_ready = 1'b0;

        // Post-reset contention: r0 first, then alternating; 4 stall cycles
        issue(1, 1, 32'd10, 32'd20, 3'd0, 32'd30, 32'd40, 3'd1, 0);
        issue(1, 1, 32'd11, 32'd11, 3'd1, 32'd7, 32'd7, 3'd2, 4);
        issue(1, 1, 32'hFF, 32'h0F, 3'd4, 32'h1, 32'h2, 3'd6, 0);
        issue(1, 1, 32'h3, 32'h5, 3'd7, 32'h0, 32'h0, 3'd7, 0);
        issue(1, 1, 32'h2, 32'h3, 3'd3, 32'h9, 32'h9, 3'd0, 0);
        r0_valid = 0; r1_valid = 0;
        @(negedge clk);

`ifdef ALU_ARB_STATS_EN
        chk("stat_grant0", stat_grant0, exp_g0);
        chk("stat_grant1", stat_grant1, exp_g1);
        chk("stat_stall", stat_stall, exp_st);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
